// File: rtl/streaming_frame_scheduler.sv
// Ping-pong frame-buffer scheduler: grants writer/reader buffers 1 cycle after request; req held until gnt.
// Build with STREAMING_SCHED_STATS_EN to get saturating frame/drop counters (otherwise stat_* read 0).
module streaming_frame_scheduler #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_en,
  input  logic [ADDR_W-1:0] cfg_wr_start0,
  input  logic [ADDR_W-1:0] cfg_wr_end0,
  input  logic [ADDR_W-1:0] cfg_wr_start1,
  input  logic [ADDR_W-1:0] cfg_wr_end1,
  input  logic              wr_req,
  output logic              wr_gnt,
  input  logic              wr_done,
  output logic [ADDR_W-1:0] wr_base,
  output logic [ADDR_W-1:0] wr_end,
  output logic              wr_sel,
  input  logic              rd_req,
  output logic              rd_gnt,
  input  logic              rd_done,
  output logic [ADDR_W-1:0] rd_base,
  output logic [ADDR_W-1:0] rd_end,
  output logic              rd_sel,
  output logic              frame_avail,
  output logic [CNT_W-1:0]  stat_wr_frames,
  output logic [CNT_W-1:0]  stat_drops
);

  typedef enum logic {W_IDLE, W_BUSY} w_state_t;
  typedef enum logic {R_IDLE, R_BUSY} r_state_t;

  w_state_t w_state_q, w_state_d;
  r_state_t r_state_q, r_state_d;

  logic latest_vld;
  logic latest_sel;
  logic wr_take, rd_take;
  logic wr_done_ok, rd_done_ok;
  logic wr_pick;
  logic wr_hits_latest;

  always_ff @(posedge clk) begin
    if (rst) begin
      w_state_q <= W_IDLE;
      r_state_q <= R_IDLE;
    end else begin
      w_state_q <= w_state_d;
      r_state_q <= r_state_d;
    end
  end

  always_comb begin
    w_state_d      = w_state_q;
    r_state_d      = r_state_q;
    wr_take        = (w_state_q == W_IDLE) && wr_req && cfg_en;
    rd_take        = (r_state_q == R_IDLE) && rd_req && cfg_en && latest_vld;
    wr_done_ok     = (w_state_q == W_BUSY) && wr_done;
    rd_done_ok     = (r_state_q == R_BUSY) && rd_done;
    wr_pick        = 1'b0;
    // A reader grant in this same cycle takes latest_sel, so the writer must steer around it.
    if (rd_take)
      wr_pick = ~latest_sel;
    else if (r_state_q == R_BUSY)
      wr_pick = ~rd_sel;
    else if (latest_vld)
      wr_pick = ~latest_sel;
    wr_hits_latest = wr_take && latest_vld && (wr_pick == latest_sel);

    if (wr_take)
      w_state_d = W_BUSY;
    else if (wr_done_ok)
      w_state_d = W_IDLE;
    if (rd_take)
      r_state_d = R_BUSY;
    else if (rd_done_ok)
      r_state_d = R_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_gnt     <= 1'b0;
      wr_base    <= '0;
      wr_end     <= '0;
      wr_sel     <= 1'b0;
      rd_gnt     <= 1'b0;
      rd_base    <= '0;
      rd_end     <= '0;
      rd_sel     <= 1'b0;
      latest_vld <= 1'b0;
      latest_sel <= 1'b0;
    end else begin
      wr_gnt <= wr_take;
      rd_gnt <= rd_take;
      if (wr_take) begin
        wr_sel  <= wr_pick;
        wr_base <= wr_pick ? cfg_wr_start1 : cfg_wr_start0;
        wr_end  <= wr_pick ? cfg_wr_end1   : cfg_wr_end0;
      end
      if (rd_take) begin
        rd_sel  <= latest_sel;
        rd_base <= latest_sel ? cfg_wr_start1 : cfg_wr_start0;
        rd_end  <= latest_sel ? cfg_wr_end1   : cfg_wr_end0;
      end
      if (wr_hits_latest)
        latest_vld <= 1'b0;
      if (wr_done_ok) begin
        latest_sel <= wr_sel;
        latest_vld <= 1'b1;
      end
      if (!cfg_en)
        latest_vld <= 1'b0;
    end
  end

  assign frame_avail = latest_vld;

`ifdef STREAMING_SCHED_STATS_EN
  logic             fresh;
  logic [CNT_W-1:0] wr_frames_q;
  logic [CNT_W-1:0] drops_q;

  // fresh marks a completed frame that no reader grant has consumed yet.
  always_ff @(posedge clk) begin
    if (rst) begin
      fresh       <= 1'b0;
      wr_frames_q <= '0;
      drops_q     <= '0;
    end else begin
      if (rd_take || wr_hits_latest)
        fresh <= 1'b0;
      if (wr_done_ok)
        fresh <= 1'b1;
      if (!cfg_en)
        fresh <= 1'b0;
      if (wr_done_ok && (wr_frames_q != {CNT_W{1'b1}}))
        wr_frames_q <= wr_frames_q + 1'b1;
      if (wr_hits_latest && fresh && (drops_q != {CNT_W{1'b1}}))
        drops_q <= drops_q + 1'b1;
    end
  end

  assign stat_wr_frames = wr_frames_q;
  assign stat_drops     = drops_q;
`else
  assign stat_wr_frames = '0;
  assign stat_drops     = '0;
`endif

endmodule

// File: tb/tb_streaming_frame_scheduler.sv
// Directed + randomized bench for streaming_frame_scheduler against a buffer-ownership reference model.
module tb_streaming_frame_scheduler;

  logic        clk = 1'b0;
  logic        rst, cfg_en;
  logic [31:0] cfg_wr_start0, cfg_wr_end0, cfg_wr_start1, cfg_wr_end1;
  logic        wr_req, wr_gnt, wr_done, wr_sel;
  logic [31:0] wr_base, wr_end;
  logic        rd_req, rd_gnt, rd_done, rd_sel;
  logic [31:0] rd_base, rd_end;
  logic        frame_avail;
  logic [15:0] stat_wr_frames, stat_drops;

  always #5 clk = ~clk;

  streaming_frame_scheduler dut (
    .clk(clk), .rst(rst), .cfg_en(cfg_en),
    .cfg_wr_start0(cfg_wr_start0), .cfg_wr_end0(cfg_wr_end0),
    .cfg_wr_start1(cfg_wr_start1), .cfg_wr_end1(cfg_wr_end1),
    .wr_req(wr_req), .wr_gnt(wr_gnt), .wr_done(wr_done),
    .wr_base(wr_base), .wr_end(wr_end), .wr_sel(wr_sel),
    .rd_req(rd_req), .rd_gnt(rd_gnt), .rd_done(rd_done),
    .rd_base(rd_base), .rd_end(rd_end), .rd_sel(rd_sel),
    .frame_avail(frame_avail),
    .stat_wr_frames(stat_wr_frames), .stat_drops(stat_drops)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model: who owns which buffer, plus the newest completed frame (-1 = none).
  int          m_wr_hold, m_rd_hold, m_newest;
  bit          m_unread;
  logic        e_wr_gnt, e_rd_gnt, e_wr_sel, e_rd_sel;
  logic [31:0] e_wr_base, e_wr_end, e_rd_base, e_rd_end;
  int unsigned e_frames, e_drops;

  function automatic logic [31:0] buf_start(int b);
    return (b == 1) ? cfg_wr_start1 : cfg_wr_start0;
  endfunction

  function automatic logic [31:0] buf_end(int b);
    return (b == 1) ? cfg_wr_end1 : cfg_wr_end0;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    int  wc, n_newest;
    bit  wg, rg, dw, dr, n_unread;
    if (rst) begin
      m_wr_hold = -1; m_rd_hold = -1; m_newest = -1; m_unread = 0;
      e_wr_gnt = 0; e_rd_gnt = 0; e_wr_sel = 0; e_rd_sel = 0;
      e_wr_base = 0; e_wr_end = 0; e_rd_base = 0; e_rd_end = 0;
      e_frames = 0; e_drops = 0;
      return;
    end
    rg = (m_rd_hold < 0) && rd_req && cfg_en && (m_newest >= 0);
    wg = (m_wr_hold < 0) && wr_req && cfg_en;
    dw = wr_done && (m_wr_hold >= 0);
    dr = rd_done && (m_rd_hold >= 0);
    if (rg)                 wc = 1 - m_newest;
    else if (m_rd_hold >= 0) wc = 1 - m_rd_hold;
    else if (m_newest >= 0)  wc = 1 - m_newest;
    else                     wc = 0;
    n_newest = m_newest;
    n_unread = m_unread;
    if (rg) n_unread = 0;
    if (wg && wc == m_newest) begin
      if (m_unread && e_drops < 16'hFFFF) e_drops++;
      n_newest = -1;
      n_unread = 0;
    end
    if (dw) begin
      n_newest = m_wr_hold;
      n_unread = 1;
      if (e_frames < 16'hFFFF) e_frames++;
    end
    if (!cfg_en) begin
      n_newest = -1;
      n_unread = 0;
    end
    e_wr_gnt = wg;
    e_rd_gnt = rg;
    if (wg) begin
      e_wr_sel = wc[0]; e_wr_base = buf_start(wc); e_wr_end = buf_end(wc);
    end
    if (rg) begin
      e_rd_sel = m_newest[0]; e_rd_base = buf_start(m_newest); e_rd_end = buf_end(m_newest);
    end
    if (rg) m_rd_hold = m_newest; else if (dr) m_rd_hold = -1;
    if (wg) m_wr_hold = wc;       else if (dw) m_wr_hold = -1;
    m_newest = n_newest;
    m_unread = n_unread;
  endtask

  task automatic check_outputs();
    logic [15:0] xf, xd;
`ifdef STREAMING_SCHED_STATS_EN
    xf = e_frames[15:0]; xd = e_drops[15:0];
`else
    xf = 16'd0; xd = 16'd0;
`endif
    chk("wr_gnt", wr_gnt, e_wr_gnt);
    chk("wr_sel", wr_sel, e_wr_sel);
    chk("wr_base", wr_base, e_wr_base);
    chk("wr_end", wr_end, e_wr_end);
    chk("rd_gnt", rd_gnt, e_rd_gnt);
    chk("rd_sel", rd_sel, e_rd_sel);
    chk("rd_base", rd_base, e_rd_base);
    chk("rd_end", rd_end, e_rd_end);
    chk("frame_avail", frame_avail, (m_newest >= 0));
    chk("stat_wr_frames", stat_wr_frames, xf);
    chk("stat_drops", stat_drops, xd);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check_outputs();
  endtask

  initial begin
    rst = 1; cfg_en = 1; wr_req = 0; wr_done = 0; rd_req = 0; rd_done = 0;
    cfg_wr_start0 = 32'h0;    cfg_wr_end0 = 32'hFFF;
    cfg_wr_start1 = 32'h1000; cfg_wr_end1 = 32'h1FFF;
    m_wr_hold = -1; m_rd_hold = -1; m_newest = -1; m_unread = 0;
    e_frames = 0; e_drops = 0;
    cycle(); cycle();
    chk("reset_wr_gnt", wr_gnt, 1'b0);
    chk("reset_avail", frame_avail, 1'b0);
    rst = 0;

    // T1: first writer grant lands in buffer 0
    wr_req = 1; cycle(); wr_req = 0;
    chk("T1_gnt", wr_gnt, 1'b1);
    chk("T1_sel", wr_sel, 1'b0);
    chk("T1_base", wr_base, 32'h0);
    chk("T1_end", wr_end, 32'hFFF);
    cycle();
    wr_done = 1; cycle(); wr_done = 0;
    chk("T2_avail", frame_avail, 1'b1);

    // T2: reader takes buffer 0, writer moves to buffer 1
    rd_req = 1; cycle(); rd_req = 0;
    chk("T2_rd_gnt", rd_gnt, 1'b1);
    chk("T2_rd_sel", rd_sel, 1'b0);
    chk("T2_rd_base", rd_base, 32'h0);
    wr_req = 1; cycle(); wr_req = 0;
    chk("T2_wr_sel", wr_sel, 1'b1);
    chk("T2_wr_base", wr_base, 32'h1000);

    // T3: unread frame in buffer 1 overwritten while reader keeps buffer 0
    wr_done = 1; cycle(); wr_done = 0;
    wr_req = 1; cycle(); wr_req = 0;
    chk("T3_wr_gnt", wr_gnt, 1'b1);
    chk("T3_wr_sel", wr_sel, 1'b1);
    chk("T3_rd_sel", rd_sel, 1'b0);
    chk("T3_avail", frame_avail, 1'b0);
`ifdef STREAMING_SCHED_STATS_EN
    chk("T3_drops", stat_drops, 16'd1);
`else
    chk("T3_drops", stat_drops, 16'd0);
`endif
    wr_done = 1; rd_done = 1; cycle(); wr_done = 0; rd_done = 0;

    // T4: reader waits for the first completed frame
    rst = 1; cycle(); rst = 0;
    rd_req = 1;
    cycle(); cycle();
    chk("T4_no_rd_gnt", rd_gnt, 1'b0);
    wr_req = 1; cycle(); wr_req = 0;
    wr_done = 1; cycle(); wr_done = 0;
    chk("T4_same_cycle_no_gnt", rd_gnt, 1'b0);
    cycle();
    chk("T4_rd_gnt", rd_gnt, 1'b1);
    rd_req = 0;

    // T5: enable dropped mid-frame
    wr_req = 1; cycle(); wr_req = 0;
    cfg_en = 0; cycle();
    wr_done = 1; cycle(); wr_done = 0;
    chk("T5_avail", frame_avail, 1'b0);
    wr_req = 1; rd_done = 1; cycle(); rd_done = 0; rd_req = 1;
    cycle(); cycle();
    chk("T5_no_wr_gnt", wr_gnt, 1'b0);
    chk("T5_no_rd_gnt", rd_gnt, 1'b0);
    cfg_en = 1; cycle(); wr_req = 0; rd_req = 0;
    chk("T5_wr_gnt_after_en", wr_gnt, 1'b1);

    // T6: reset with both sides busy
    wr_done = 1; cycle(); wr_done = 0;
    rd_req = 1; cycle(); rd_req = 0;
    wr_req = 1; cycle(); wr_req = 0;
    rst = 1; cycle(); rst = 0;
    chk("T6_wr_base", wr_base, 32'h0);
    chk("T6_rd_base", rd_base, 32'h0);
    chk("T6_frames", stat_wr_frames, 16'd0);

    // Randomized traffic, config churn, enable drops and resets
    for (int i = 0; i < 4000; i++) begin
      rst     = ($urandom_range(0, 299) == 0);
      cfg_en  = ($urandom_range(0, 24) != 0);
      wr_req  = ($urandom_range(0, 2) != 0);
      wr_done = ($urandom_range(0, 3) == 0);
      rd_req  = ($urandom_range(0, 1) != 0);
      rd_done = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 39) == 0) begin
        cfg_wr_start0 = $urandom; cfg_wr_end0 = $urandom;
        cfg_wr_start1 = $urandom; cfg_wr_end1 = $urandom;
      end
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
